mealy_step_ctrl: RTL and testbench
==================================

MEALY_STEP_CTRL -- requirements
Module: mealy_step_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive equal synchronized samples required to accept a button level change.
REQ-002 SHALL have parameter TICK_DIV, default 8: base auto-run step period in clk cycles (range 2..65535).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port btn_step, input, 1: raw asynchronous single-step push button.
REQ-006 SHALL have port run_en, input, 1: auto-run request (level).
REQ-007 SHALL have port rate_sel, input, 2: auto-run period = TICK_DIV << rate_sel.
REQ-008 SHALL have port load_req, input, 1: one-cycle pulse requesting state preload.
REQ-009 SHALL have port load_state, input, 3: value to preload into the stepped FSM.
REQ-010 SHALL have port halt_en, input, 1: enables stop-on-state during auto-run.
REQ-011 SHALL have port halt_state, input, 3: state value that halts auto-run.
REQ-012 SHALL have port fsm_state, input, 3: current state reported by the stepped FSM.
REQ-013 SHALL have port fsm_ctrl, output, 1: registered one-cycle step enable to the FSM.
REQ-014 SHALL have port fsm_reset, output, 1: registered one-cycle preload strobe to the FSM.
REQ-015 SHALL have port fsm_state_in, output, 3: registered preload value, valid while fsm_reset=1.
REQ-016 SHALL have port step_count, output, 8: number of fsm_ctrl pulses since the last reset or load.
REQ-017 SHALL have port running, output, 1: high while in RUN.
REQ-018 SHALL have port halted, output, 1: sticky flag set when auto-run stops on halt_state.

Function
REQ-019 SHALL synchronize btn_step through two flops, then debounce: btn_db changes only after DEB_CYCLES consecutive equal synchronized samples; shorter glitches are ignored.
REQ-020 SHALL implement states IDLE, LOAD, STEP, WAIT_REL, RUN.
REQ-021 In IDLE, priority SHALL be load_req > run_en rising edge > btn_db rising edge.
REQ-022 LOAD SHALL last one cycle: fsm_reset=1, fsm_state_in=load_state captured with load_req, step_count cleared to 0, halted cleared; next state IDLE.
REQ-023 STEP SHALL last one cycle with fsm_ctrl=1 and step_count+1; next state WAIT_REL.
REQ-024 WAIT_REL SHALL return to IDLE only when btn_db=0, so one press yields exactly one step.
REQ-025 Entering RUN SHALL clear the prescaler and halted; fsm_ctrl SHALL pulse once every TICK_DIV<<rate_sel cycles, first pulse that many cycles after entry.
REQ-026 rate_sel changes during RUN SHALL take effect at the next prescaler terminal count.
REQ-027 RUN SHALL exit to IDLE when run_en=0, with no further fsm_ctrl pulse.
REQ-028 In RUN with halt_en=1, the cycle after an fsm_ctrl pulse, fsm_state==halt_state SHALL set halted=1 and move to IDLE.
REQ-029 After a halt, RUN SHALL be re-entered only on a new run_en rising edge.
REQ-030 load_req in RUN, STEP or WAIT_REL SHALL be taken next cycle (go to LOAD), suppressing any coincident fsm_ctrl pulse; fsm_ctrl and fsm_reset SHALL never be high together.
REQ-031 load_req arriving while in LOAD SHALL be ignored.
REQ-032 step_count SHALL wrap 255 -> 0.
REQ-033 btn_db rising edges while in RUN SHALL be ignored.

Reset
REQ-034 reset=1 SHALL force, on the next edge: state IDLE; fsm_ctrl=0, fsm_reset=0, fsm_state_in=0, step_count=0, running=0, halted=0; sync flops, debounce counter, btn_db and prescaler cleared.
REQ-035 reset asserted mid-RUN or mid-LOAD SHALL abort the operation with no further fsm_ctrl or fsm_reset pulse.

Verification
REQ-036 Press btn_step for 20 cycles -> exactly one fsm_ctrl pulse, step_count=1; a 2-cycle glitch -> no pulse.
REQ-037 load_req with load_state=2 -> one fsm_reset cycle with fsm_state_in=2, step_count=0.
REQ-038 run_en=1, rate_sel=1, TICK_DIV=8 -> fsm_ctrl every 16 cycles; run_en=0 -> pulses stop, running=0.
REQ-039 RUN, halt_en=1, halt_state=0, fsm_state model reaching 0 -> halted=1, IDLE; run_en held high -> no restart.
REQ-040 load_req coincident with a RUN terminal count -> fsm_reset only, no fsm_ctrl, then IDLE.
REQ-041 256 single steps -> step_count wraps to 0; reset mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mealy_step_ctrl.sv
// Step/run controller for an externally stepped FSM: debounced single-step button,
// prescaled auto-run with stop-on-state, and a one-cycle state preload path.
module mealy_step_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int TICK_DIV   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_step,
    input  logic       run_en,
    input  logic [1:0] rate_sel,
    input  logic       load_req,
    input  logic [2:0] load_state,
    input  logic       halt_en,
    input  logic [2:0] halt_state,
    input  logic [2:0] fsm_state,
    output logic       fsm_ctrl,
    output logic       fsm_reset,
    output logic [2:0] fsm_state_in,
    output logic [7:0] step_count,
    output logic       running,
    output logic       halted,
    output logic [2:0] state_dbg
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int PW = 19;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        STEP     = 3'd2,
        WAIT_REL = 3'd3,
        RUN      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic            btn_db_q, btn_db_d, btn_prev_q, btn_prev_d;
    logic            run_prev_q, run_prev_d;
    logic [PW-1:0]   presc_q, presc_d, period_q, period_d;
    logic            halt_chk_q, halt_chk_d;
    logic            fsm_ctrl_q, fsm_ctrl_d, fsm_reset_q, fsm_reset_d;
    logic [2:0]      fsm_state_in_q, fsm_state_in_d;
    logic [7:0]      step_count_q, step_count_d;
    logic            running_q, running_d, halted_q, halted_d;

    logic            btn_rise, run_rise, tc, take_load;
    logic [PW-1:0]   period_sel;

    always_comb begin
        state_d        = state_q;
        sync1_d        = btn_step;
        sync2_d        = sync1_q;
        deb_cnt_d      = deb_cnt_q;
        btn_db_d       = btn_db_q;
        btn_prev_d     = btn_db_q;
        run_prev_d     = run_en;
        presc_d        = presc_q;
        period_d       = period_q;
        fsm_ctrl_d     = 1'b0;
        fsm_reset_d    = 1'b0;
        fsm_state_in_d = fsm_state_in_q;
        step_count_d   = step_count_q;
        halted_d       = halted_q;
        take_load      = 1'b0;
        // The halt compare looks at fsm_state one cycle after the pulse the FSM consumed.
        halt_chk_d     = (state_q == RUN) && fsm_ctrl_q;

        btn_rise   = btn_db_q && !btn_prev_q;
        run_rise   = run_en && !run_prev_q;
        period_sel = PW'(TICK_DIV) << rate_sel;
        tc         = (presc_q == period_q - 1'b1);

        if (sync2_q == btn_db_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
            btn_db_d  = !btn_db_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_req) begin
                    take_load = 1'b1;
                end else if (run_rise) begin
                    state_d  = RUN;
                    presc_d  = '0;
                    period_d = period_sel;
                    halted_d = 1'b0;
                end else if (btn_rise) begin
                    state_d      = STEP;
                    fsm_ctrl_d   = 1'b1;
                    step_count_d = step_count_q + 8'd1;
                end
            end
            LOAD: state_d = IDLE;
            STEP: begin
                if (load_req) take_load = 1'b1;
                else          state_d   = WAIT_REL;
            end
            WAIT_REL: begin
                if (load_req)       take_load = 1'b1;
                else if (!btn_db_q) state_d   = IDLE;
            end
            RUN: begin
                if (load_req) begin
                    take_load = 1'b1;
                end else if (!run_en) begin
                    state_d = IDLE;
                end else if (halt_en && halt_chk_q && (fsm_state == halt_state)) begin
                    state_d  = IDLE;
                    halted_d = 1'b1;
                end else if (tc) begin
                    // New rate_sel is only sampled here, so a running period is never cut short.
                    fsm_ctrl_d   = 1'b1;
                    step_count_d = step_count_q + 8'd1;
                    presc_d      = '0;
                    period_d     = period_sel;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_load) begin
            state_d        = LOAD;
            fsm_ctrl_d     = 1'b0;
            fsm_reset_d    = 1'b1;
            fsm_state_in_d = load_state;
            step_count_d   = 8'd0;
            halted_d       = 1'b0;
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_cnt_q      <= '0;
            btn_db_q       <= 1'b0;
            btn_prev_q     <= 1'b0;
            run_prev_q     <= 1'b0;
            presc_q        <= '0;
            period_q       <= '0;
            halt_chk_q     <= 1'b0;
            fsm_ctrl_q     <= 1'b0;
            fsm_reset_q    <= 1'b0;
            fsm_state_in_q <= 3'd0;
            step_count_q   <= 8'd0;
            running_q      <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            deb_cnt_q      <= deb_cnt_d;
            btn_db_q       <= btn_db_d;
            btn_prev_q     <= btn_prev_d;
            run_prev_q     <= run_prev_d;
            presc_q        <= presc_d;
            period_q       <= period_d;
            halt_chk_q     <= halt_chk_d;
            fsm_ctrl_q     <= fsm_ctrl_d;
            fsm_reset_q    <= fsm_reset_d;
            fsm_state_in_q <= fsm_state_in_d;
            step_count_q   <= step_count_d;
            running_q      <= running_d;
            halted_q       <= halted_d;
        end
    end

    assign fsm_ctrl     = fsm_ctrl_q;
    assign fsm_reset    = fsm_reset_q;
    assign fsm_state_in = fsm_state_in_q;
    assign step_count   = step_count_q;
    assign running      = running_q;
    assign halted       = halted_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mealy_step_ctrl.sv
// Directed bench for mealy_step_ctrl with a small stepped-FSM model driving fsm_state.
module tb_mealy_step_ctrl;

    logic       clk = 1'b0;
    logic       reset, btn_step, run_en, load_req, halt_en;
    logic [1:0] rate_sel;
    logic [2:0] load_state, halt_state, fsm_state;
    logic       fsm_ctrl, fsm_reset, running, halted;
    logic [2:0] fsm_state_in, state_dbg;
    logic [7:0] step_count;

    always #5 clk = ~clk;

    mealy_step_ctrl #(.DEB_CYCLES(4), .TICK_DIV(8)) dut (
        .clk(clk), .reset(reset), .btn_step(btn_step), .run_en(run_en),
        .rate_sel(rate_sel), .load_req(load_req), .load_state(load_state),
        .halt_en(halt_en), .halt_state(halt_state), .fsm_state(fsm_state),
        .fsm_ctrl(fsm_ctrl), .fsm_reset(fsm_reset), .fsm_state_in(fsm_state_in),
        .step_count(step_count), .running(running), .halted(halted),
        .state_dbg(state_dbg)
    );

    // Stepped FSM model: a 3-bit counter that preloads on fsm_reset and advances on fsm_ctrl.
    always @(posedge clk) begin
        if (reset)          fsm_state <= 3'd0;
        else if (fsm_reset) fsm_state <= fsm_state_in;
        else if (fsm_ctrl)  fsm_state <= fsm_state + 3'd1;
    end

    int ctrl_cnt = 0;
    int rst_cnt  = 0;
    bit overlap_seen = 1'b0;

    always @(negedge clk) begin
        if (fsm_ctrl)              ctrl_cnt++;
        if (fsm_reset)             rst_cnt++;
        if (fsm_ctrl && fsm_reset) overlap_seen = 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input int len);
        btn_step = 1'b1;
        cyc(len);
        btn_step = 1'b0;
    endtask

    // Returns cycles until fsm_ctrl is seen, or 9999 if the bound expires.
    task automatic wait_pulse(output int n);
        n = 9999;
        for (int k = 1; k <= 2000; k++) begin
            cyc(1);
            if (fsm_ctrl) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fsm_ctrl"},     fsm_ctrl,     0);
        check({tag, "_fsm_reset"},    fsm_reset,    0);
        check({tag, "_fsm_state_in"}, fsm_state_in, 0);
        check({tag, "_step_count"},   step_count,   0);
        check({tag, "_running"},      running,      0);
        check({tag, "_halted"},       halted,       0);
        check({tag, "_state"},        state_dbg,    0);
    endtask

    typedef struct {
        int press_len;
        int exp_pulses;
    } deb_vec_t;

    typedef struct {
        logic [1:0] rate;
        int         exp_period;
    } rate_vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        deb_vec_t  deb_tab[4];
        rate_vec_t rate_tab[4];
        int exp_sc, c0, r0, n;

        deb_tab[0] = '{20, 1};
        deb_tab[1] = '{2, 0};
        deb_tab[2] = '{3, 0};
        deb_tab[3] = '{4, 1};
        rate_tab[0] = '{2'd0, 8};
        rate_tab[1] = '{2'd1, 16};
        rate_tab[2] = '{2'd2, 32};
        rate_tab[3] = '{2'd3, 64};

        reset = 1'b1; btn_step = 1'b0; run_en = 1'b0; rate_sel = 2'd0;
        load_req = 1'b0; load_state = 3'd0; halt_en = 1'b0; halt_state = 3'd0;
        cyc(3);
        check_all_zero("reset");
        reset = 1'b0;
        cyc(2);

        // Debounce: only presses of at least DEB_CYCLES samples produce one step.
        exp_sc = 0;
        foreach (deb_tab[i]) begin
            c0 = ctrl_cnt;
            press(deb_tab[i].press_len);
            cyc(20);
            exp_sc += deb_tab[i].exp_pulses;
            check("deb_pulses", ctrl_cnt - c0, deb_tab[i].exp_pulses);
            check("deb_step_count", step_count, exp_sc);
        end

        // Preload from IDLE.
        load_state = 3'd2; load_req = 1'b1;
        cyc(1);
        check("load_fsm_reset", fsm_reset, 1);
        check("load_state_in", fsm_state_in, 2);
        check("load_step_count", step_count, 0);
        check("load_no_ctrl", fsm_ctrl, 0);
        load_req = 1'b0;
        cyc(1);
        check("load_end_reset", fsm_reset, 0);
        check("load_end_idle", state_dbg, 0);
        check("load_model_state", fsm_state, 2);
        exp_sc = 0;

        // Auto-run periods for every rate_sel (one extra cycle of run_en edge detect).
        foreach (rate_tab[i]) begin
            rate_sel = rate_tab[i].rate;
            run_en = 1'b1;
            wait_pulse(n);
            check("run_first_latency", n, rate_tab[i].exp_period + 1);
            check("run_running", running, 1);
            wait_pulse(n);
            check("run_period", n, rate_tab[i].exp_period);
            run_en = 1'b0;
            c0 = ctrl_cnt;
            cyc(2 * rate_tab[i].exp_period);
            exp_sc += 2;
            check("run_stop_pulses", ctrl_cnt - c0, 0);
            check("run_stop_running", running, 0);
            check("run_step_count", step_count, exp_sc);
        end

        // rate_sel change mid-period only applies from the next terminal count.
        rate_sel = 2'd0; run_en = 1'b1;
        wait_pulse(n);
        rate_sel = 2'd2;
        wait_pulse(n);
        check("rate_change_old_period", n, 8);
        wait_pulse(n);
        check("rate_change_new_period", n, 32);
        run_en = 1'b0;
        cyc(4);
        exp_sc += 3;
        check("rate_change_step_count", step_count, exp_sc);

        // Halt on state 0 starting from preload 5: pulses 5->6->7->0 then stop.
        load_state = 3'd5; load_req = 1'b1;
        cyc(1);
        load_req = 1'b0;
        cyc(1);
        halt_en = 1'b1; halt_state = 3'd0; rate_sel = 2'd0;
        c0 = ctrl_cnt;
        run_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cyc(1);
            if (halted) break;
        end
        check("halt_flag", halted, 1);
        check("halt_running", running, 0);
        check("halt_pulses", ctrl_cnt - c0, 3);
        check("halt_model_state", fsm_state, 0);
        check("halt_step_count", step_count, 3);
        cyc(40);
        check("halt_no_restart_pulses", ctrl_cnt - c0, 3);
        check("halt_no_restart_running", running, 0);
        check("halt_sticky", halted, 1);
        run_en = 1'b0;
        cyc(2);
        run_en = 1'b1;
        cyc(2);
        check("rerun_running", running, 1);
        check("rerun_halted_clear", halted, 0);
        run_en = 1'b0;
        cyc(2);
        check("rerun_stop", running, 0);
        halt_en = 1'b0;

        // load_req on the terminal-count cycle wins over the run pulse.
        rate_sel = 2'd0;
        c0 = ctrl_cnt; r0 = rst_cnt;
        run_en = 1'b1;
        cyc(8);
        load_state = 3'd6; load_req = 1'b1;
        cyc(1);
        check("tc_load_reset", fsm_reset, 1);
        check("tc_load_no_ctrl", fsm_ctrl, 0);
        check("tc_load_state_in", fsm_state_in, 6);
        check("tc_load_step_count", step_count, 0);
        load_req = 1'b0; run_en = 1'b0;
        cyc(1);
        check("tc_load_idle", state_dbg, 0);
        check("tc_load_running", running, 0);
        check("tc_load_reset_end", fsm_reset, 0);
        cyc(10);
        check("tc_load_ctrl_total", ctrl_cnt - c0, 0);
        check("tc_load_reset_total", rst_cnt - r0, 1);

        // 256 single steps wrap the counter back to zero.
        c0 = ctrl_cnt;
        for (int i = 0; i < 256; i++) begin
            press(10);
            cyc(10);
            if (i == 254) check("wrap_255", step_count, 255);
        end
        check("wrap_0", step_count, 0);
        check("wrap_pulses", ctrl_cnt - c0, 256);

        // Reset in the middle of RUN.
        rate_sel = 2'd0; run_en = 1'b1;
        cyc(12);
        check("prereset_step_count", step_count, 1);
        reset = 1'b1; run_en = 1'b0;
        cyc(1);
        check_all_zero("run_reset");
        reset = 1'b0;
        c0 = ctrl_cnt; r0 = rst_cnt;
        cyc(20);
        check("run_reset_no_ctrl", ctrl_cnt - c0, 0);
        check("run_reset_no_load", rst_cnt - r0, 0);

        // Reset while in LOAD.
        load_state = 3'd7; load_req = 1'b1;
        cyc(1);
        check("midload_reset_high", fsm_reset, 1);
        load_req = 1'b0; reset = 1'b1;
        cyc(1);
        check("midload_fsm_reset", fsm_reset, 0);
        check("midload_state_in", fsm_state_in, 0);
        check("midload_state", state_dbg, 0);
        reset = 1'b0;
        r0 = rst_cnt;
        cyc(5);
        check("midload_no_more_reset", rst_cnt - r0, 0);

        check("ctrl_reset_overlap", overlap_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
